// File: rtl/cordic_engine_if.sv
// Operand/result bus for cordic_engine: input and output valid/ready pairs plus busy.
// No storage; the engine owns all timing.
// master = sample source/consumer side, slave = engine side.
interface cordic_engine_if #(
  parameter int WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    mode;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic        [31:0]      z_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] x_out;
  logic signed [WIDTH-1:0] y_out;
  logic        [31:0]      z_out;
  logic                    busy;

  modport master (
    output in_valid, mode, x_in, y_in, z_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, z_out, busy
  );

  modport slave (
    input  in_valid, mode, x_in, y_in, z_in, out_ready,
    output in_ready, out_valid, x_out, y_out, z_out, busy
  );
endinterface

// File: rtl/cordic_engine.sv
// Iterative CORDIC (rotation: sin/cos/rotate, vectoring: magnitude/phase) on one shared add/shift datapath.
// Latency: out_valid rises ITER edges after accept (ITER+1 with CORDIC_GAIN_COMP_EN); one operation in flight.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready. Optional macro CORDIC_GAIN_COMP_EN adds a 1/K scale step.
module cordic_engine #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  cordic_engine_if.slave  bus
);
  // Two guard bits absorb the CORDIC gain (~1.65) and the sqrt(2) vector growth.
  localparam int W2 = WIDTH + 2;
  localparam logic [4:0] LAST = 5'(ITER - 1);
  localparam logic signed [W2-1:0] SAT_MAX = W2'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [W2-1:0] SAT_MIN = W2'(-(2 ** (WIDTH - 1)));

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
`ifdef CORDIC_GAIN_COMP_EN
    SCALE,
`endif
    DONE
  } state_t;

  state_t                  state_q;
  logic                    mode_q;
  logic        [4:0]       i_q;
  logic signed [W2-1:0]    x_q, y_q;
  logic        [31:0]      z_q;
  logic signed [WIDTH-1:0] x_out_q, y_out_q;
  logic        [31:0]      z_out_q;
  logic                    out_valid_q;
  logic                    busy_q;

  logic signed [W2-1:0]    x_ext, y_ext;
  logic signed [W2-1:0]    xl_d, yl_d;
  logic        [31:0]      zl_d;
  logic signed [W2-1:0]    x_shr, y_shr;
  logic signed [W2-1:0]    x_d, y_d;
  logic        [31:0]      z_d;
  logic        [31:0]      atan_i;
  logic                    d_pos;

  // atan(2^-i) in binary-angle units (2^32 = 360 degrees), rounded.
  function automatic logic [31:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:  atan_lut = 32'h2000_0000;
      5'd1:  atan_lut = 32'h12E4_051E;
      5'd2:  atan_lut = 32'h09FB_385B;
      5'd3:  atan_lut = 32'h0511_11D4;
      5'd4:  atan_lut = 32'h028B_0D43;
      5'd5:  atan_lut = 32'h0145_D7E1;
      5'd6:  atan_lut = 32'h00A2_F61E;
      5'd7:  atan_lut = 32'h0051_7C55;
      5'd8:  atan_lut = 32'h0028_BE53;
      5'd9:  atan_lut = 32'h0014_5F2F;
      5'd10: atan_lut = 32'h000A_2F98;
      5'd11: atan_lut = 32'h0005_17CC;
      5'd12: atan_lut = 32'h0002_8BE6;
      5'd13: atan_lut = 32'h0001_45F3;
      5'd14: atan_lut = 32'h0000_A2FA;
      5'd15: atan_lut = 32'h0000_517D;
      5'd16: atan_lut = 32'h0000_28BE;
      5'd17: atan_lut = 32'h0000_145F;
      5'd18: atan_lut = 32'h0000_0A30;
      5'd19: atan_lut = 32'h0000_0518;
      5'd20: atan_lut = 32'h0000_028C;
      5'd21: atan_lut = 32'h0000_0146;
      5'd22: atan_lut = 32'h0000_00A3;
      5'd23: atan_lut = 32'h0000_0051;
      5'd24: atan_lut = 32'h0000_0029;
      5'd25: atan_lut = 32'h0000_0014;
      5'd26: atan_lut = 32'h0000_000A;
      5'd27: atan_lut = 32'h0000_0005;
      5'd28: atan_lut = 32'h0000_0003;
      5'd29: atan_lut = 32'h0000_0001;
      default: atan_lut = 32'h0000_0000;
    endcase
  endfunction

  // Clamp a guarded internal value to the signed output range.
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [W2-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[WIDTH-1:0];
    else                  sat = v[WIDTH-1:0];
  endfunction

  // Quadrant pre-rotation so the iterations only ever cover +/-99.9 degrees.
  always_comb begin
    x_ext = W2'(bus.x_in);
    y_ext = W2'(bus.y_in);
    xl_d  = x_ext;
    yl_d  = y_ext;
    zl_d  = bus.z_in;
    if (!bus.mode) begin
      case (bus.z_in[31:30])
        2'b01: begin xl_d = -y_ext; yl_d = x_ext;  zl_d = {2'b00, bus.z_in[29:0]}; end
        2'b10: begin xl_d = y_ext;  yl_d = -x_ext; zl_d = {2'b11, bus.z_in[29:0]}; end
        default: ;
      endcase
    end else if (x_ext[W2-1]) begin
      if (!y_ext[W2-1]) begin
        xl_d = y_ext;  yl_d = -x_ext; zl_d = bus.z_in + 32'h4000_0000;
      end else begin
        xl_d = -y_ext; yl_d = x_ext;  zl_d = bus.z_in - 32'h4000_0000;
      end
    end
  end

  // One micro-rotation: drive z toward 0 (rotation) or y toward 0 (vectoring).
  always_comb begin
    x_shr  = x_q >>> i_q;
    y_shr  = y_q >>> i_q;
    atan_i = atan_lut(i_q);
    d_pos  = mode_q ? y_q[W2-1] : !z_q[31];
    if (d_pos) begin
      x_d = x_q - y_shr;
      y_d = y_q + x_shr;
      z_d = z_q - atan_i;
    end else begin
      x_d = x_q + y_shr;
      y_d = y_q - x_shr;
      z_d = z_q + atan_i;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam int PW = W2 + 18;
  logic signed [PW-1:0] px, py;
  logic signed [W2-1:0] xg_d, yg_d;

  // Multiply by round(2^16/K) with round-to-nearest to remove the CORDIC gain.
  always_comb begin
    px   = PW'(x_q) * PW'(39797) + PW'(32768);
    py   = PW'(y_q) * PW'(39797) + PW'(32768);
    xg_d = W2'(px >>> 16);
    yg_d = W2'(py >>> 16);
  end
`endif

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      i_q         <= 5'd0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      z_out_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            x_q     <= xl_d;
            y_q     <= yl_d;
            z_q     <= zl_d;
            mode_q  <= bus.mode;
            i_q     <= 5'd0;
            busy_q  <= 1'b1;
            state_q <= ROTATE;
          end
        end
        ROTATE: begin
          x_q <= x_d;
          y_q <= y_d;
          z_q <= z_d;
          i_q <= i_q + 5'd1;
          if (i_q == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
            state_q <= SCALE;
`else
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            x_out_q     <= sat(x_d);
            y_out_q     <= sat(y_d);
            z_out_q     <= z_d;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        SCALE: begin
          state_q     <= DONE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
          x_out_q     <= sat(xg_d);
          y_out_q     <= sat(yg_d);
          z_out_q     <= z_q;
        end
`endif
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.x_out     = x_out_q;
  assign bus.y_out     = y_out_q;
  assign bus.z_out     = z_out_q;
  assign bus.busy      = busy_q;
endmodule
